clk_div_mon: RTL

Clock-divider monitor that sits directly downstream of the pll-folder clock dividers. It samples a divided clock that is generated synchronously in the `clk_in` domain and emits single-cycle rise and fall strobes for downstream logic. It also measures each divided-clock period in `clk_in` cycles and reports lock once a run of consecutive periods matches the expected ratio. Divider faults (stuck output, wrong ratio, missing edges) are flagged through a saturating error counter and a timeout indication.

---
 rtl/clk_div_mon.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/clk_div_mon.sv
// Divided-clock monitor: edge strobes, period measurement, lock tracking and fault
// reporting for a divider output generated synchronously in the clk_in domain.
module clk_div_mon #(
  parameter int EXP_PERIOD = 4,
  parameter int TOL        = 0,
  parameter int LOCK_CNT   = 8,
  parameter int LOSS_CNT   = 2,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             div_clk_i,
  input  logic             clear_i,
  output logic             rise_stb_o,
  output logic             fall_stb_o,
  output logic [CNT_W-1:0] period_o,
  output logic             period_vld_o,
  output logic             locked_o,
  output logic             timeout_o,
  output logic [7:0]       err_cnt_o
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);
  localparam logic [CNT_W:0]   EXP_W     = (CNT_W + 1)'(EXP_PERIOD);
  localparam logic [CNT_W:0]   TOL_W     = (CNT_W + 1)'(TOL);
  localparam logic [CNT_W-1:0] TO_VAL    = CNT_W'(TIMEOUT - 1);
  localparam logic [GW-1:0]    LOCK_LAST = GW'(LOCK_CNT - 1);
  localparam logic [BW-1:0]    LOSS_LAST = BW'(LOSS_CNT - 1);

  typedef enum logic [1:0] {ACQ, TRACK, LOCKED} state_t;

  state_t           state;
  logic             s0, s1;
  logic             rise_det, fall_det, timeout_ev, good;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W:0]   per_w, dev;
  logic [GW-1:0]    good_cnt;
  logic [BW-1:0]    bad_cnt;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign rise_det   = s0 & ~s1;
  assign fall_det   = ~s0 & s1;
  assign per_w      = {1'b0, per_cnt};
  assign dev        = (per_w >= EXP_W) ? per_w - EXP_W : EXP_W - per_w;
  assign good       = (dev <= TOL_W);
  // per_cnt runs past TO_VAL during a stall, so this fires once per stall
  assign timeout_ev = (per_cnt == TO_VAL) && !rise_det;

  // The sampler is deliberately untouched by clear_i so a clear never fabricates an edge.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s0         <= 1'b0;
      s1         <= 1'b0;
      rise_stb_o <= 1'b0;
      fall_stb_o <= 1'b0;
    end else begin
      // NOTE: non-blocking so s1 takes the previous s0; blocking would collapse the detector.
      s0         <= div_clk_i;
      s1         <= s0;
      rise_stb_o <= rise_det;
      fall_stb_o <= fall_det;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state        <= ACQ;
      per_cnt      <= '0;
      good_cnt     <= '0;
      bad_cnt      <= '0;
      err_cnt_o    <= '0;
      period_o     <= '0;
      period_vld_o <= 1'b0;
      locked_o     <= 1'b0;
      timeout_o    <= 1'b0;
    end else if (clear_i) begin
      state        <= ACQ;
      per_cnt      <= '0;
      good_cnt     <= '0;
      bad_cnt      <= '0;
      err_cnt_o    <= '0;
      period_o     <= '0;
      period_vld_o <= 1'b0;
      locked_o     <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      period_vld_o <= 1'b0;
      if (rise_det)             per_cnt <= CNT_W'(1);
      else if (per_cnt != '1)   per_cnt <= per_cnt + CNT_W'(1);

      if (rise_det) begin
        timeout_o <= 1'b0;
        case (state)
          ACQ: begin
            state    <= TRACK;
            good_cnt <= '0;
            bad_cnt  <= '0;
          end
          TRACK: begin
            period_o     <= per_cnt;
            period_vld_o <= 1'b1;
            if (good) begin
              good_cnt <= good_cnt + GW'(1);
              if (good_cnt == LOCK_LAST) begin
                state    <= LOCKED;
                locked_o <= 1'b1;
                bad_cnt  <= '0;
              end
            end else begin
              good_cnt  <= '0;
              err_cnt_o <= sat_inc(err_cnt_o);
            end
          end
          LOCKED: begin
            period_o     <= per_cnt;
            period_vld_o <= 1'b1;
            if (good) begin
              bad_cnt <= '0;
            end else begin
              err_cnt_o <= sat_inc(err_cnt_o);
              if (bad_cnt == LOSS_LAST) begin
                state    <= TRACK;
                locked_o <= 1'b0;
                good_cnt <= '0;
                bad_cnt  <= '0;
              end else begin
                bad_cnt <= bad_cnt + BW'(1);
              end
            end
          end
          default: begin
            state    <= ACQ;
            locked_o <= 1'b0;
          end
        endcase
      end else if (timeout_ev) begin
        state     <= ACQ;
        locked_o  <= 1'b0;
        timeout_o <= 1'b1;
        err_cnt_o <= sat_inc(err_cnt_o);
      end
    end
  end

endmodule
